// File: rtl/imem_if.sv
// imem_if: request/acknowledge bus between the fetch sequencer and instruction memory.
interface imem_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    modport master (output imem_req, imem_addr, input imem_rdata, imem_ack);
    modport slave (input imem_req, imem_addr, output imem_rdata, imem_ack);
endinterface

// File: rtl/ifetch_sequencer.sv
// ifetch_sequencer: holds the PC, fetches one instruction at a time over imem_if,
// computes sequential/branch next PC, counts retirements and flags fetch timeouts.
module ifetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    imem_if.master      imem,
    output logic [31:0] o_instr,
    output logic [5:0]  o_opcode,
    output logic        o_instr_valid,
    input  logic        i_advance,
    input  logic        i_npc_sel,
    input  logic        i_halt,
    output logic [31:0] o_pc,
    output logic [31:0] o_retired,
    output logic        o_halted,
    output logic        o_fault
);
    typedef enum logic [2:0] {BOOT, FETCH, EXEC, HALT, FAULT} state_t;
    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};
    localparam logic [7:0]  WAIT_LIMIT = 8'(MAX_WAIT);
    state_t      r_state, w_next;
    logic [31:0] r_pc, r_instr, r_retired, w_br_off;
    logic [7:0]  r_wait;
    logic        r_valid, w_ack, w_retire;
    assign w_ack    = r_state == FETCH && imem.imem_ack;
    assign w_retire = r_state == EXEC && i_advance;
    assign w_br_off = i_npc_sel ? {{14{r_instr[15]}}, r_instr[15:0], 2'b00} : 32'd0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= BOOT;
        else r_state <= w_next;
    end
    // An ack in the final allowed wait cycle wins over the timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            BOOT:    w_next = FETCH;
            FETCH:   w_next = imem.imem_ack ? EXEC : (r_wait + 8'd1 == WAIT_LIMIT) ? FAULT : FETCH;
            EXEC:    w_next = !i_advance ? EXEC : i_halt ? HALT : FETCH;
            default: w_next = r_state;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= PC_INIT;
            r_instr   <= 32'd0;
            r_valid   <= 1'b0;
            r_retired <= 32'd0;
            r_wait    <= 8'd0;
        end else begin
            if (r_state == FETCH) r_wait <= w_ack ? 8'd0 : r_wait + 8'd1;
            if (w_ack) begin
                r_instr <= imem.imem_rdata;
                r_valid <= 1'b1;
            end
            if (w_retire) begin
                r_valid   <= 1'b0;
                r_retired <= r_retired + 32'd1;
                r_pc      <= r_pc + 32'd4 + w_br_off;
            end
        end
    end
    assign imem.imem_req  = r_state == FETCH;
    assign imem.imem_addr = r_pc;
    assign o_instr        = r_instr;
    assign o_opcode       = r_instr[31:26];
    assign o_instr_valid  = r_valid;
    assign o_pc           = r_pc;
    assign o_retired      = r_retired;
    assign o_halted       = r_state == HALT;
    assign o_fault        = r_state == FAULT;
endmodule

// File: tb/tb_ifetch_sequencer.sv
// tb_ifetch_sequencer: directed fetch/branch vectors plus halt, async-reset and timeout sequences.
module tb_ifetch_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] o_instr, o_pc, o_retired;
    logic [5:0]  o_opcode;
    logic        o_instr_valid, o_halted, o_fault;
    logic        i_advance = 1'b0, i_npc_sel = 1'b0, i_halt = 1'b0;
    int          checks = 0, errors = 0;
    imem_if bus();
    ifetch_sequencer #(.RESET_PC(32'h0000_0000), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst), .imem(bus), .o_instr(o_instr), .o_opcode(o_opcode),
        .o_instr_valid(o_instr_valid), .i_advance(i_advance), .i_npc_sel(i_npc_sel),
        .i_halt(i_halt), .o_pc(o_pc), .o_retired(o_retired), .o_halted(o_halted),
        .o_fault(o_fault)
    );
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          delay;
        logic [31:0] rdata;
        logic        npc;
        logic [31:0] next_pc;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!bus.imem_req && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", 32'(bus.imem_req), 32'd1);
    endtask

    task automatic fetch(input int delay, input logic [31:0] rdata);
        repeat (delay) tick();
        bus.imem_ack = 1'b1;
        bus.imem_rdata = rdata;
        tick();
        bus.imem_ack = 1'b0;
        chk("instr", o_instr, rdata);
        chk("opcode", 32'(o_opcode), 32'(rdata[31:26]));
        chk("valid_after_ack", 32'(o_instr_valid), 32'd1);
        chk("req_low_exec", 32'(bus.imem_req), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input logic [31:0] exp_ret);
        wait_req();
        chk("imem_addr", bus.imem_addr, v.addr);
        chk("pc_fetch", o_pc, v.addr);
        fetch(v.delay, v.rdata);
        i_advance = 1'b1;
        i_npc_sel = v.npc;
        tick();
        i_advance = 1'b0;
        i_npc_sel = 1'b0;
        chk("next_pc", o_pc, v.next_pc);
        chk("valid_retired", 32'(o_instr_valid), 32'd0);
        chk("retired", o_retired, exp_ret);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h0000_0000, 1, 32'h0000_0020, 1'b0, 32'h0000_0004};
        vecs[1]  = '{32'h0000_0004, 1, 32'h0000_0020, 1'b0, 32'h0000_0008};
        vecs[2]  = '{32'h0000_0008, 1, 32'h0000_0020, 1'b0, 32'h0000_000C};
        vecs[3]  = '{32'h0000_000C, 0, 32'h1000_0000, 1'b1, 32'h0000_0010};
        vecs[4]  = '{32'h0000_0010, 0, 32'h1000_0003, 1'b0, 32'h0000_0014};
        vecs[5]  = '{32'h0000_0014, 0, 32'h1000_FFFE, 1'b1, 32'h0000_0010};
        vecs[6]  = '{32'h0000_0010, 0, 32'h1000_0003, 1'b1, 32'h0000_0020};
        vecs[7]  = '{32'h0000_0020, 2, 32'h1000_FFF9, 1'b1, 32'h0000_0008};
        vecs[8]  = '{32'h0000_0008, 0, 32'h1000_FFFD, 1'b1, 32'h0000_0000};
        vecs[9]  = '{32'h0000_0000, 0, 32'h1000_FFFE, 1'b1, 32'hFFFF_FFFC};
        vecs[10] = '{32'hFFFF_FFFC, 0, 32'h8C00_0000, 1'b0, 32'h0000_0000};
        vecs[11] = '{32'h0000_0000, 0, 32'h1000_FFF0, 1'b0, 32'h0000_0004};
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'd0;
        #12;
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_pc", o_pc, 32'd0);
        chk("rst_instr", o_instr, 32'd0);
        chk("rst_opcode", 32'(o_opcode), 32'd0);
        chk("rst_retired", o_retired, 32'd0);
        chk("rst_flags", {29'd0, o_instr_valid, o_halted, o_fault}, 32'd0);
        #1 rst = 1'b0;
        #1 chk("boot_no_req", 32'(bus.imem_req), 32'd0);
        for (int i = 0; i < 12; i++) run_vec(vecs[i], 32'(i + 1));

        // stall in EXEC with halt/nPC_sel asserted and a spurious ack
        wait_req();
        chk("halt_fetch_addr", bus.imem_addr, 32'h0000_0004);
        fetch(0, 32'h0000_0020);
        i_halt = 1'b1;
        i_npc_sel = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.imem_ack = (i == 5);
            bus.imem_rdata = 32'hFFFF_FFFF;
            tick();
            chk("stall_pc", o_pc, 32'h0000_0004);
            chk("stall_instr", o_instr, 32'h0000_0020);
        end
        bus.imem_ack = 1'b0;
        chk("stall_retired", o_retired, 32'd12);
        chk("stall_valid", 32'(o_instr_valid), 32'd1);
        chk("stall_req", 32'(bus.imem_req), 32'd0);
        i_npc_sel = 1'b0;
        i_advance = 1'b1;
        tick();
        i_advance = 1'b0;
        i_halt = 1'b0;
        chk("halted", 32'(o_halted), 32'd1);
        chk("halt_retired", o_retired, 32'd13);
        chk("halt_pc", o_pc, 32'h0000_0008);
        repeat (5) tick();
        chk("halt_no_req", 32'(bus.imem_req), 32'd0);
        chk("halt_sticky", 32'(o_halted), 32'd1);

        // async reset mid-fetch
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("refetch_req", 32'(bus.imem_req), 32'd1);
        #2;
        rst = 1'b1;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hAAAA_AAAA;
        #1 chk("async_req_drop", 32'(bus.imem_req), 32'd0);
        tick();
        bus.imem_ack = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_boot_req", 32'(bus.imem_req), 32'd0);
        chk("async_instr", o_instr, 32'd0);
        chk("async_halted", 32'(o_halted), 32'd0);
        tick();
        chk("post_boot_req", 32'(bus.imem_req), 32'd1);
        chk("post_boot_addr", bus.imem_addr, 32'd0);

        // ack in the last allowed wait cycle still succeeds
        run_vec('{32'h0000_0000, 3, 32'h2108_0001, 1'b0, 32'h0000_0004}, 32'd1);

        // timeout: never ack
        chk("to_req_start", 32'(bus.imem_req), 32'd1);
        repeat (3) tick();
        chk("to_no_fault_yet", 32'(o_fault), 32'd0);
        chk("to_req_still", 32'(bus.imem_req), 32'd1);
        tick();
        chk("to_fault", 32'(o_fault), 32'd1);
        chk("to_req_low", 32'(bus.imem_req), 32'd0);
        chk("to_pc", o_pc, 32'h0000_0004);
        chk("to_valid", 32'(o_instr_valid), 32'd0);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.imem_ack = 1'b0;
        chk("to_late_ack_instr", o_instr, 32'h2108_0001);
        chk("to_fault_sticky", 32'(o_fault), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
